// File: rtl/vectored_irq_arbiter_if.sv
// Peripheral and CPU facing signals of the vectored interrupt arbiter.
// The slave modport is the arbiter's view; the master modport is the peripherals' and CPU's view.
interface vectored_irq_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   virq_req;
  logic [NREQ*9-1:0] virq_vec;
  logic [NREQ-1:0]   virq_mask;
  logic [NREQ-1:0]   virq_ack;
  logic              cpu_virq;
  logic [8:0]        cpu_vector;
  logic              cpu_iack;
  logic [7:0]        timeout_cnt;

  modport slave (
    input  virq_req, virq_vec, virq_mask, cpu_iack,
    output virq_ack, cpu_virq, cpu_vector, timeout_cnt
  );

  modport master (
    output virq_req, virq_vec, virq_mask, cpu_iack,
    input  virq_ack, cpu_virq, cpu_vector, timeout_cnt
  );
endinterface

// File: rtl/vectored_irq_arbiter.sv
// Arbitrates NREQ level-held vectored interrupt requests onto the CPU's single
// vectored interrupt input. It presents the winner's vector and acks only the winner.
module vectored_irq_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned RR           = 0,
  parameter int unsigned ACK_TIMEOUT  = 255,
  parameter logic [8:0]  SPURIOUS_VEC = 9'o000
) (
  input logic                   clk_bus,
  input logic                   bus_reset,
  vectored_irq_arbiter_if.slave bus
);

  localparam int unsigned IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned VECW    = 9;
  localparam logic [7:0]  TO_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEND,
    ST_WAIT_DROP,
    ST_WAIT_IACK
  } state_t;

  state_t            r_state;
  logic [NREQ-1:0]   r_ack;
  logic              r_cpu_virq;
  logic [VECW-1:0]   r_cpu_vector;
  logic [7:0]        r_timeout_cnt;
  logic [IDXW-1:0]   r_ptr;
  logic [IDXW-1:0]   r_win;
  logic [7:0]        r_hold_cnt;
  logic              r_iack_q;

  state_t            w_nxt_state;
  logic [NREQ-1:0]   w_nxt_ack;
  logic              w_nxt_virq;
  logic [VECW-1:0]   w_nxt_vector;
  logic [7:0]        w_nxt_tcnt;
  logic [IDXW-1:0]   w_nxt_ptr;
  logic [IDXW-1:0]   w_nxt_win;
  logic [7:0]        w_nxt_hold;

  logic [NREQ-1:0]   w_eligible;
  logic [IDXW-1:0]   w_win;
  logic              w_win_valid;
  logic [VECW-1:0]   w_win_vec;
  logic              w_iack_edge;
  int unsigned       w_idx;

  assign w_eligible  = bus.virq_req & ~bus.virq_mask;
  assign w_iack_edge = bus.cpu_iack & ~r_iack_q;

  // The winner search starts at index 0, or at the rotating pointer in round-robin mode.
  always_comb begin
    w_win       = '0;
    w_win_valid = 1'b0;
    w_idx       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = ((RR != 0) ? 32'(r_ptr) : 32'd0) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_win_valid && w_eligible[IDXW'(w_idx)]) begin
        w_win       = IDXW'(w_idx);
        w_win_valid = 1'b1;
      end
    end
  end

  // Vectors are word aligned, so bit 0 of each slice is forced to zero.
  always_comb begin
    w_win_vec = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_win == IDXW'(i)) w_win_vec = bus.virq_vec[VECW*i +: VECW] & 9'h1FE;
    end
  end

  always_ff @(posedge clk_bus or posedge bus_reset) begin
    if (bus_reset) begin
      r_state       <= ST_IDLE;
      r_ack         <= '0;
      r_cpu_virq    <= 1'b0;
      r_cpu_vector  <= '0;
      r_timeout_cnt <= '0;
      r_ptr         <= '0;
      r_win         <= '0;
      r_hold_cnt    <= '0;
      r_iack_q      <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_ack         <= w_nxt_ack;
      r_cpu_virq    <= w_nxt_virq;
      r_cpu_vector  <= w_nxt_vector;
      r_timeout_cnt <= w_nxt_tcnt;
      r_ptr         <= w_nxt_ptr;
      r_win         <= w_nxt_win;
      r_hold_cnt    <= w_nxt_hold;
      r_iack_q      <= bus.cpu_iack;
    end
  end

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_ack    = r_ack;
    w_nxt_virq   = r_cpu_virq;
    w_nxt_vector = r_cpu_vector;
    w_nxt_tcnt   = r_timeout_cnt;
    w_nxt_ptr    = r_ptr;
    w_nxt_win    = r_win;
    w_nxt_hold   = r_hold_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_win_valid) begin
          w_nxt_state  = ST_PEND;
          w_nxt_virq   = 1'b1;
          w_nxt_vector = w_win_vec;
        end
      end
      ST_PEND: begin
        // At the iack edge, the eligible value sampled in that cycle decides whether the iack is real or spurious.
        if (w_iack_edge) begin
          if (w_win_valid) begin
            w_nxt_state  = ST_WAIT_DROP;
            w_nxt_ack    = NREQ'(1) << w_win;
            w_nxt_vector = w_win_vec;
            w_nxt_win    = w_win;
            w_nxt_hold   = '0;
            w_nxt_ptr    = (w_win == IDXW'(NREQ - 1)) ? '0 : w_win + IDXW'(1);
          end else begin
            w_nxt_state  = ST_WAIT_IACK;
            w_nxt_vector = SPURIOUS_VEC;
          end
        end else if (!w_win_valid) begin
          w_nxt_state  = ST_IDLE;
          w_nxt_virq   = 1'b0;
          w_nxt_vector = '0;
        end else begin
          w_nxt_vector = w_win_vec;
        end
      end
      ST_WAIT_DROP: begin
        // The raw req is used here, so masking the winner does not abort its handshake.
        if (!bus.virq_req[r_win]) begin
          w_nxt_state = ST_WAIT_IACK;
          w_nxt_ack   = '0;
        end else if (r_hold_cnt == TO_LAST) begin
          w_nxt_state = ST_WAIT_IACK;
          w_nxt_ack   = '0;
          if (r_timeout_cnt != 8'hFF) w_nxt_tcnt = r_timeout_cnt + 8'd1;
        end else begin
          w_nxt_hold = r_hold_cnt + 8'd1;
        end
      end
      ST_WAIT_IACK: begin
        if (!bus.cpu_iack) begin
          w_nxt_state  = ST_IDLE;
          w_nxt_virq   = 1'b0;
          w_nxt_vector = '0;
        end
      end
      default: w_nxt_state = ST_IDLE;
    endcase
  end

  assign bus.virq_ack    = r_ack;
  assign bus.cpu_virq    = r_cpu_virq;
  assign bus.cpu_vector  = r_cpu_vector;
  assign bus.timeout_cnt = r_timeout_cnt;

endmodule

// File: tb/tb_vectored_irq_arbiter.sv
// Directed bench for vectored_irq_arbiter: a fixed-priority instance and a round-robin
// instance, both with ACK_TIMEOUT=4.
module tb_vectored_irq_arbiter;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  logic rst_r = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  vectored_irq_arbiter_if #(.NREQ(NREQ)) f_if ();
  vectored_irq_arbiter_if #(.NREQ(NREQ)) r_if ();

  vectored_irq_arbiter #(.NREQ(NREQ), .RR(0), .ACK_TIMEOUT(4), .SPURIOUS_VEC(9'o000)) u_fixed (
    .clk_bus(clk), .bus_reset(rst_f), .bus(f_if));
  vectored_irq_arbiter #(.NREQ(NREQ), .RR(1), .ACK_TIMEOUT(4), .SPURIOUS_VEC(9'o000)) u_rr (
    .clk_bus(clk), .bus_reset(rst_r), .bus(r_if));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    f_if.virq_req = '0; f_if.virq_mask = '0; f_if.cpu_iack = 1'b0;
    f_if.virq_vec = {9'o000, 9'o274, 9'o060, 9'o100};
    r_if.virq_req = '0; r_if.virq_mask = '0; r_if.cpu_iack = 1'b0;
    r_if.virq_vec = {9'o000, 9'o274, 9'o060, 9'o100};
    #2; rst_f = 1'b1; rst_r = 1'b1;
    #1;
    total_cnt++; if (f_if.virq_ack !== 4'b0000) $display("FAIL rst_ack: got %b want 0000", f_if.virq_ack); else pass_cnt++;
    total_cnt++; if (f_if.cpu_virq !== 1'b0) $display("FAIL rst_virq: got %b want 0", f_if.cpu_virq); else pass_cnt++;
    total_cnt++; if (f_if.cpu_vector !== 9'o000) $display("FAIL rst_vector: got %o want 000", f_if.cpu_vector); else pass_cnt++;
    total_cnt++; if (f_if.timeout_cnt !== 8'd0) $display("FAIL rst_tcnt: got %0d want 0", f_if.timeout_cnt); else pass_cnt++;
    tick();
    rst_f = 1'b0; rst_r = 1'b0;
    tick();
  endtask

  task automatic test_basic_handshake();
    f_if.virq_req = 4'b0010;
    tick();
    total_cnt++; if (f_if.cpu_virq !== 1'b1) $display("FAIL t1_virq_rise: got %b want 1", f_if.cpu_virq); else pass_cnt++;
    total_cnt++; if (f_if.cpu_vector !== 9'o060) $display("FAIL t1_vector: got %o want 060", f_if.cpu_vector); else pass_cnt++;
    tick(); tick();
    total_cnt++; if (f_if.virq_ack !== 4'b0000) $display("FAIL t1_no_early_ack: got %b want 0000", f_if.virq_ack); else pass_cnt++;
    f_if.cpu_iack = 1'b1;
    tick();
    total_cnt++; if (f_if.virq_ack !== 4'b0010) $display("FAIL t1_ack_rise: got %b want 0010", f_if.virq_ack); else pass_cnt++;
    tick();
    total_cnt++; if (f_if.virq_ack !== 4'b0010) $display("FAIL t1_ack_hold: got %b want 0010", f_if.virq_ack); else pass_cnt++;
    f_if.virq_req = 4'b0000;
    tick();
    total_cnt++; if (f_if.virq_ack !== 4'b0000) $display("FAIL t1_ack_fall: got %b want 0000", f_if.virq_ack); else pass_cnt++;
    total_cnt++; if (f_if.cpu_virq !== 1'b1 || f_if.cpu_vector !== 9'o060)
      $display("FAIL t1_wait_iack: got virq=%b vec=%o want virq=1 vec=060", f_if.cpu_virq, f_if.cpu_vector); else pass_cnt++;
    f_if.cpu_iack = 1'b0;
    tick();
    total_cnt++; if (f_if.cpu_virq !== 1'b0 || f_if.cpu_vector !== 9'o000)
      $display("FAIL t1_idle: got virq=%b vec=%o want virq=0 vec=000", f_if.cpu_virq, f_if.cpu_vector); else pass_cnt++;
  endtask

  task automatic test_preempt();
    f_if.virq_req = 4'b0100;
    tick();
    total_cnt++; if (f_if.cpu_vector !== 9'o274) $display("FAIL t2_vec_274: got %o want 274", f_if.cpu_vector); else pass_cnt++;
    f_if.virq_req = 4'b0101;
    tick();
    total_cnt++; if (f_if.cpu_vector !== 9'o100) $display("FAIL t2_vec_100: got %o want 100", f_if.cpu_vector); else pass_cnt++;
    f_if.cpu_iack = 1'b1;
    tick();
    total_cnt++; if (f_if.virq_ack !== 4'b0001) $display("FAIL t2_ack0: got %b want 0001", f_if.virq_ack); else pass_cnt++;
    f_if.virq_req = 4'b0100;
    tick();
    f_if.cpu_iack = 1'b0;
    tick();
    total_cnt++; if (f_if.cpu_virq !== 1'b0) $display("FAIL t2_idle: got %b want 0", f_if.cpu_virq); else pass_cnt++;
    tick();
    total_cnt++; if (f_if.cpu_virq !== 1'b1 || f_if.cpu_vector !== 9'o274)
      $display("FAIL t2_req2_served: got virq=%b vec=%o want virq=1 vec=274", f_if.cpu_virq, f_if.cpu_vector); else pass_cnt++;
    f_if.cpu_iack = 1'b1;
    tick();
    total_cnt++; if (f_if.virq_ack !== 4'b0100) $display("FAIL t2_ack2: got %b want 0100", f_if.virq_ack); else pass_cnt++;
    f_if.virq_req = 4'b0000;
    tick();
    f_if.cpu_iack = 1'b0;
    tick();
  endtask

  task automatic test_mask();
    f_if.virq_req = 4'b0011; f_if.virq_mask = 4'b0001;
    tick();
    total_cnt++; if (f_if.cpu_vector !== 9'o060) $display("FAIL mask_vec: got %o want 060", f_if.cpu_vector); else pass_cnt++;
    f_if.cpu_iack = 1'b1;
    tick();
    f_if.virq_mask = 4'b0010;
    tick();
    total_cnt++; if (f_if.virq_ack !== 4'b0010) $display("FAIL mask_no_abort: got %b want 0010", f_if.virq_ack); else pass_cnt++;
    f_if.virq_req = 4'b0000;
    tick();
    f_if.cpu_iack = 1'b0; f_if.virq_mask = 4'b0000;
    tick();
  endtask

  task automatic test_drop_in_pend();
    logic seen_ack;
    seen_ack = 1'b0;
    f_if.virq_req = 4'b0010;
    tick();
    seen_ack = seen_ack | (|f_if.virq_ack);
    f_if.virq_req = 4'b0000;
    tick();
    total_cnt++; if (f_if.cpu_virq !== 1'b0) $display("FAIL t3_virq_fall: got %b want 0", f_if.cpu_virq); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      seen_ack = seen_ack | (|f_if.virq_ack);
      tick();
    end
    total_cnt++; if (seen_ack !== 1'b0) $display("FAIL t3_no_ack: got %b want 0", seen_ack); else pass_cnt++;
  endtask

  task automatic test_spurious();
    f_if.virq_req = 4'b0010;
    tick();
    f_if.virq_req = 4'b0000; f_if.cpu_iack = 1'b1;
    tick();
    total_cnt++; if (f_if.cpu_vector !== 9'o000 || f_if.cpu_virq !== 1'b1)
      $display("FAIL t4_spurious: got virq=%b vec=%o want virq=1 vec=000", f_if.cpu_virq, f_if.cpu_vector); else pass_cnt++;
    total_cnt++; if (f_if.virq_ack !== 4'b0000) $display("FAIL t4_no_ack: got %b want 0000", f_if.virq_ack); else pass_cnt++;
    f_if.cpu_iack = 1'b0;
    tick();
    total_cnt++; if (f_if.cpu_virq !== 1'b0) $display("FAIL t4_idle: got %b want 0", f_if.cpu_virq); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    int bad;
    bad = 0;
    f_if.virq_req = 4'b0010;
    tick();
    f_if.cpu_iack = 1'b1;
    tick();
    n = 0;
    while (f_if.virq_ack[1] === 1'b1 && n < 20) begin n++; tick(); end
    total_cnt++; if (n != 4) $display("FAIL t5_ack_len: got %0d want 4", n); else pass_cnt++;
    total_cnt++; if (f_if.timeout_cnt !== 8'd1) $display("FAIL t5_tcnt1: got %0d want 1", f_if.timeout_cnt); else pass_cnt++;
    for (int rep = 1; rep < 300; rep++) begin
      f_if.cpu_iack = 1'b0;
      tick(); tick();
      f_if.cpu_iack = 1'b1;
      tick();
      n = 0;
      while (f_if.virq_ack[1] === 1'b1 && n < 20) begin n++; tick(); end
      if (n != 4) bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL t5_repeat_len: got %0d bad repeats want 0", bad); else pass_cnt++;
    total_cnt++; if (f_if.timeout_cnt !== 8'd255) $display("FAIL t5_tcnt_sat: got %0d want 255", f_if.timeout_cnt); else pass_cnt++;
    f_if.virq_req = 4'b0000; f_if.cpu_iack = 1'b0;
    tick(); tick();
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] exp_ack [4];
    exp_ack[0] = 4'b0001; exp_ack[1] = 4'b0010; exp_ack[2] = 4'b0001; exp_ack[3] = 4'b0010;
    r_if.virq_req = 4'b0011;
    for (int it = 0; it < 4; it++) begin
      tick();
      r_if.cpu_iack = 1'b1;
      tick();
      total_cnt++; if (r_if.virq_ack !== exp_ack[it])
        $display("FAIL t6_rr_ack%0d: got %b want %b", it, r_if.virq_ack, exp_ack[it]); else pass_cnt++;
      n = 0;
      while ((|r_if.virq_ack) && n < 20) begin n++; tick(); end
      r_if.cpu_iack = 1'b0;
      tick();
    end
    tick();
    r_if.cpu_iack = 1'b1;
    tick();
    total_cnt++; if (r_if.virq_ack !== 4'b0001) $display("FAIL t6_pre_rst_ack: got %b want 0001", r_if.virq_ack); else pass_cnt++;
    rst_r = 1'b1;
    #1;
    total_cnt++; if (r_if.virq_ack !== 4'b0000 || r_if.cpu_virq !== 1'b0 || r_if.cpu_vector !== 9'o000 || r_if.timeout_cnt !== 8'd0)
      $display("FAIL t6_async_rst: got ack=%b virq=%b vec=%o tcnt=%0d want all 0",
               r_if.virq_ack, r_if.cpu_virq, r_if.cpu_vector, r_if.timeout_cnt); else pass_cnt++;
    #1;
    rst_r = 1'b0; r_if.cpu_iack = 1'b0;
    tick();
    total_cnt++; if (r_if.cpu_virq !== 1'b1 || r_if.cpu_vector !== 9'o100)
      $display("FAIL t6_reserve: got virq=%b vec=%o want virq=1 vec=100", r_if.cpu_virq, r_if.cpu_vector); else pass_cnt++;
    r_if.virq_req = 4'b0000;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_handshake();
    test_preempt();
    test_mask();
    test_drop_in_pend();
    test_spurious();
    test_timeout();
    test_round_robin();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
